// File: rtl/register_write_arbiter.sv
// Register-bank write-port arbiter: round-robin grant among NUM_REQ writeback
// sources, combinational one-hot GNT, registered WRITE/WR_ADDR/WR_DATA, and a
// LOCKED mode that keeps the port on one owner for multi-register bursts.
module register_write_arbiter #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4,
  parameter int NUM_REQ   = 3
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_REQ-1:0]             REQ,
  input  logic [NUM_REQ-1:0]             LOCK,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   REQ_ADDR,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   REQ_DATA,
  input  logic                           HOLD,
  output logic [NUM_REQ-1:0]             GNT,
  output logic                           WRITE,
  output logic [ADDR_SIZE-1:0]           WR_ADDR,
  output logic [DATA_SIZE-1:0]           WR_DATA,
  output logic                           BUSY
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_IDLE, S_LOCKED} state_e;

  state_e                 state_q;
  logic [PW-1:0]          ptr_q, owner_q;
  logic                   write_q, busy_q;
  logic [ADDR_SIZE-1:0]   wr_addr_q;
  logic [DATA_SIZE-1:0]   wr_data_q;

  logic [PW-1:0]          win_idx, gnt_idx;
  logic                   win_vld, gnt_vld;
  logic [PW:0]            sum;
  logic [PW-1:0]          idx;

  // Successor of a requester index, wrapping at NUM_REQ-1.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] i);
    return (i == PW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // Round-robin search: first set REQ bit at or above ptr_q, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
      idx = sum[PW-1:0];
      if (!win_vld && REQ[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  // Grant: owner only while locked, round-robin winner otherwise; HOLD and reset block all.
  always_comb begin
    GNT     = '0;
    gnt_vld = 1'b0;
    gnt_idx = win_idx;
    if (RST && !HOLD) begin
      if (state_q == S_LOCKED) begin
        gnt_idx = owner_q;
        gnt_vld = REQ[owner_q];
      end else begin
        gnt_vld = win_vld;
      end
    end
    if (gnt_vld) GNT[gnt_idx] = 1'b1;
  end

  // FSM plus registered write port; reset drops any lock and pending write.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      write_q <= gnt_vld;
      if (gnt_vld) begin
        wr_addr_q <= REQ_ADDR[gnt_idx*ADDR_SIZE +: ADDR_SIZE];
        wr_data_q <= REQ_DATA[gnt_idx*DATA_SIZE +: DATA_SIZE];
      end
      case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            ptr_q <= nxt(gnt_idx);
            if (LOCK[gnt_idx]) begin
              state_q <= S_LOCKED;
              owner_q <= gnt_idx;
              busy_q  <= 1'b1;
            end
          end
        end
        S_LOCKED: begin
          // Leave once the owner drops LOCK, either on a granted write or
          // when it has no request left; PTR stays frozen until then.
          if (!LOCK[owner_q] && (gnt_vld || !REQ[owner_q])) begin
            state_q <= S_IDLE;
            ptr_q   <= nxt(owner_q);
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign WRITE   = write_q;
  assign WR_ADDR = wr_addr_q;
  assign WR_DATA = wr_data_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Bench for register_write_arbiter: directed stimulus with literal checks,
// plus a queue-free behavioural model compared against the DUT every cycle.
module tb_register_write_arbiter;
  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 32;

  logic              CLK = 1'b0;
  logic              RST;
  logic [N-1:0]      REQ, LOCK;
  logic              HOLD;
  logic [N*AW-1:0]   REQ_ADDR;
  logic [N*DW-1:0]   REQ_DATA;
  logic [N-1:0]      GNT;
  logic              WRITE, BUSY;
  logic [AW-1:0]     WR_ADDR;
  logic [DW-1:0]     WR_DATA;

  int errs   = 0;
  int checks = 0;

  register_write_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .NUM_REQ(N)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .LOCK(LOCK), .REQ_ADDR(REQ_ADDR),
    .REQ_DATA(REQ_DATA), .HOLD(HOLD), .GNT(GNT), .WRITE(WRITE),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: locked flag, owner, priority pointer, and the write
  // that must appear on the port after the next edge.
  bit          m_lock;
  int          m_own, m_ptr;
  bit          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  always @(negedge CLK) begin
    int eg;
    if (!RST) begin
      chk("rst_gnt",   32'(GNT),     0);
      chk("rst_write", 32'(WRITE),   0);
      chk("rst_addr",  32'(WR_ADDR), 0);
      chk("rst_data",  WR_DATA,      0);
      chk("rst_busy",  32'(BUSY),    0);
      m_lock = 0; m_own = 0; m_ptr = 0; m_wr = 0; m_addr = '0; m_data = '0;
    end else begin
      chk("mdl_write", 32'(WRITE), 32'(m_wr));
      if (m_wr) begin
        chk("mdl_addr", 32'(WR_ADDR), 32'(m_addr));
        chk("mdl_data", WR_DATA, m_data);
      end
      chk("mdl_busy", 32'(BUSY), 32'(m_lock));
      eg = -1;
      if (!HOLD) begin
        if (m_lock) begin
          if (REQ[m_own]) eg = m_own;
        end else begin
          for (int k = 0; k < N; k++)
            if (eg < 0 && REQ[(m_ptr + k) % N]) eg = (m_ptr + k) % N;
        end
      end
      chk("mdl_gnt", 32'(GNT), (eg < 0) ? 0 : (1 << eg));
      m_wr = (eg >= 0);
      if (eg >= 0) begin
        m_addr = REQ_ADDR[eg*AW +: AW];
        m_data = REQ_DATA[eg*DW +: DW];
      end
      if (m_lock) begin
        if (!LOCK[m_own] && (eg >= 0 || !REQ[m_own])) begin
          m_lock = 0;
          m_ptr  = (m_own + 1) % N;
        end
      end else if (eg >= 0) begin
        m_ptr = (eg + 1) % N;
        if (LOCK[eg]) begin
          m_lock = 1;
          m_own  = eg;
        end
      end
    end
  end

  // Drive one cycle of inputs just after the edge, then let GNT settle.
  task automatic go(input logic [N-1:0] r, input logic [N-1:0] l, input logic h);
    @(posedge CLK);
    #1;
    REQ = r; LOCK = l; HOLD = h;
    #1;
  endtask

  logic [N-1:0] rr_exp [6];

  initial begin
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    RST = 1'b1; REQ = '0; LOCK = '0; HOLD = 1'b0;
    REQ_ADDR = {4'h2, 4'h1, 4'h0};
    REQ_DATA = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    #2 RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    go(3'b000, 3'b000, 1'b0);
    chk("idle_write", 32'(WRITE), 0);

    // Round-robin with all three requesting
    for (int i = 0; i < 6; i++) begin
      go(3'b111, 3'b000, 1'b0);
      chk("rr_gnt", 32'(GNT), 32'(rr_exp[i]));
      if (i > 0) begin
        chk("rr_write", 32'(WRITE), 1);
        chk("rr_addr", 32'(WR_ADDR), 32'((i - 1) % 3));
      end
    end
    go(3'b000, 3'b000, 1'b0);
    chk("rr_tail_gnt", 32'(GNT), 0);
    chk("rr_tail_write", 32'(WRITE), 1);
    chk("rr_tail_addr", 32'(WR_ADDR), 2);
    go(3'b000, 3'b000, 1'b0);
    chk("rr_drop_write", 32'(WRITE), 0);

    // Latency and data path
    REQ_ADDR[7:4]  = 4'hE;
    REQ_DATA[63:32] = 32'hDEAD_BEEF;
    go(3'b010, 3'b000, 1'b0);
    chk("lat_gnt", 32'(GNT), 32'b010);
    chk("lat_write_t", 32'(WRITE), 0);
    go(3'b000, 3'b000, 1'b0);
    chk("lat_write", 32'(WRITE), 1);
    chk("lat_addr", 32'(WR_ADDR), 32'hE);
    chk("lat_data", WR_DATA, 32'hDEAD_BEEF);
    go(3'b000, 3'b000, 1'b0);
    chk("lat_write_off", 32'(WRITE), 0);

    // Locked burst by requester 1 (pointer brought to 1 first)
    go(3'b001, 3'b000, 1'b0);
    chk("pre_gnt", 32'(GNT), 32'b001);
    go(3'b111, 3'b010, 1'b0);
    chk("lk_gnt1", 32'(GNT), 32'b010);
    chk("lk_busy1", 32'(BUSY), 0);
    go(3'b111, 3'b010, 1'b0);
    chk("lk_gnt2", 32'(GNT), 32'b010);
    chk("lk_busy2", 32'(BUSY), 1);
    go(3'b111, 3'b010, 1'b0);
    chk("lk_gnt3", 32'(GNT), 32'b010);
    chk("lk_busy3", 32'(BUSY), 1);
    go(3'b111, 3'b000, 1'b0);
    chk("lk_gnt4", 32'(GNT), 32'b010);
    chk("lk_busy4", 32'(BUSY), 1);
    go(3'b111, 3'b000, 1'b0);
    chk("lk_next_gnt", 32'(GNT), 32'b100);
    chk("lk_busy5", 32'(BUSY), 0);

    // HOLD blocks grants and freezes the pointer
    go(3'b101, 3'b000, 1'b1);
    chk("hold_gnt1", 32'(GNT), 0);
    go(3'b101, 3'b000, 1'b1);
    chk("hold_gnt2", 32'(GNT), 0);
    chk("hold_write2", 32'(WRITE), 0);
    go(3'b101, 3'b000, 1'b1);
    chk("hold_write3", 32'(WRITE), 0);
    go(3'b101, 3'b000, 1'b0);
    chk("hold_rel_gnt", 32'(GNT), 32'b001);
    go(3'b101, 3'b000, 1'b0);
    chk("hold_rel_gnt2", 32'(GNT), 32'b100);
    chk("hold_rel_addr", 32'(WR_ADDR), 0);

    // Wrap from requester 2 back to 0
    go(3'b100, 3'b000, 1'b0);
    chk("wrap_gnt2", 32'(GNT), 32'b100);
    go(3'b101, 3'b000, 1'b0);
    chk("wrap_gnt0", 32'(GNT), 32'b001);

    // LOCK without REQ is ignored
    go(3'b000, 3'b010, 1'b0);
    chk("ill_gnt", 32'(GNT), 0);
    go(3'b000, 3'b000, 1'b0);
    chk("ill_busy", 32'(BUSY), 0);

    // Reset in the middle of a locked burst
    go(3'b111, 3'b111, 1'b0);
    chk("rb_gnt", 32'(GNT), 32'b010);
    go(3'b111, 3'b111, 1'b0);
    chk("rb_busy", 32'(BUSY), 1);
    #1 RST = 1'b0;
    #1;
    chk("rb_gnt_now", 32'(GNT), 0);
    chk("rb_write_now", 32'(WRITE), 0);
    chk("rb_busy_now", 32'(BUSY), 0);
    @(posedge CLK);
    #1;
    chk("rb_write_hold", 32'(WRITE), 0);
    RST = 1'b1; REQ = 3'b111; LOCK = 3'b000;
    #1;
    chk("rb_first_gnt", 32'(GNT), 32'b001);
    go(3'b000, 3'b000, 1'b0);
    chk("rb_first_write", 32'(WRITE), 1);
    chk("rb_first_addr", 32'(WR_ADDR), 0);
    go(3'b000, 3'b000, 1'b0);
    go(3'b000, 3'b000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
